spi_norm_master: RTL and testbench



---
 rtl/spi_norm_master.sv | 136 +++++++++++++
 tb/tb_spi_norm_master.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_norm_master.sv
// rtl/spi_norm_master.sv - SPI mode-0 master byte engine with load_data/busy handshake
//
// Purpose: shifts one 8-bit word out on mosi (MSB first) while shifting miso in,
// SCK = clk / (2*DIV_FREQ_BY), idle low, data launched on falling and sampled on rising SCK.
//
// Ports:
//   clk            system clock, all logic on the rising edge
//   rst            asynchronous active-high reset, aborts any transfer
//   data[7:0]      word to transmit, sampled on the load edge
//   load_data      start request, acted on only in IDLE
//   miso           serial input
//   mosi           serial output
//   cs             chip select, active low
//   sck            serial clock
//   busy           transfer in progress (includes load_data combinationally)
//   received_data  last completed received word
module spi_norm_master #(
  parameter int DIV_FREQ_BY = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       load_data,
  input  logic       miso,
  output logic       mosi,
  output logic       cs,
  output logic       sck,
  output logic       busy,
  output logic [7:0] received_data
);

  localparam int CW = (DIV_FREQ_BY > 1) ? $clog2(DIV_FREQ_BY) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV_FREQ_BY - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [CW-1:0]   div_cnt;
  logic [3:0]      half_idx;
  logic [7:0]      tx_sr;
  logic [7:0]      rx_sr;
  logic            half_end;

  // Last clk cycle of the current SCK half-period.
  assign half_end = (div_cnt == DIV_LAST);

  // A registered requester must see busy in the same cycle it raises load_data.
  assign busy = !rst && ((state != IDLE) || load_data);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (load_data) state_next = SHIFT;
      SHIFT:   if (half_end && (half_idx == 4'd15)) state_next = HOLD;
      HOLD:    if (half_end) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs            <= 1'b1;
      sck           <= 1'b0;
      mosi          <= 1'b0;
      received_data <= 8'h00;
      tx_sr         <= 8'h00;
      rx_sr         <= 8'h00;
      div_cnt       <= '0;
      half_idx      <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (load_data) begin
            tx_sr    <= data;
            rx_sr    <= 8'h00;
            cs       <= 1'b0;
            mosi     <= data[7];
            sck      <= 1'b0;
            div_cnt  <= '0;
            half_idx <= 4'd0;
          end
        end
        SHIFT: begin
          if (half_end) begin
            div_cnt <= '0;
            if (half_idx == 4'd15) begin
              sck <= 1'b0;
            end else begin
              half_idx <= half_idx + 4'd1;
              // Leaving an even half means SCK rises: sample. Leaving an odd half: SCK falls, launch next bit.
              if (!half_idx[0]) begin
                sck   <= 1'b1;
                rx_sr <= {rx_sr[6:0], miso};
              end else begin
                sck   <= 1'b0;
                mosi  <= tx_sr[6];
                tx_sr <= {tx_sr[6:0], 1'b0};
              end
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        HOLD: begin
          if (half_end) begin
            div_cnt       <= '0;
            cs            <= 1'b1;
            mosi          <= 1'b0;
            received_data <= rx_sr;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        default: begin
          cs   <= 1'b1;
          sck  <= 1'b0;
          mosi <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_norm_master.sv
// tb/tb_spi_norm_master.sv - scoreboard testbench for spi_norm_master
module tb_spi_norm_master;

  localparam int D = 3;

  logic       clk;
  logic       rst;
  logic [7:0] data;
  logic       load_data;
  logic       miso;
  logic       mosi;
  logic       cs;
  logic       sck;
  logic       busy;
  logic [7:0] received_data;
  logic       loop_en;
  bit         b2b_mode;

  int n_checks;
  int n_fail;

  logic [15:0] exp_q[$];

  assign miso = loop_en ? mosi : 1'b0;

  spi_norm_master #(.DIV_FREQ_BY(D)) dut (
    .clk           (clk),
    .rst           (rst),
    .data          (data),
    .load_data     (load_data),
    .miso          (miso),
    .mosi          (mosi),
    .cs            (cs),
    .sck           (sck),
    .busy          (busy),
    .received_data (received_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: samples on the falling clk edge, reconstructs each transfer and
  // compares it against the scoreboard entry when cs returns high.
  logic       prev_cs;
  logic       prev_sck;
  bit         in_xfer;
  logic [7:0] got_tx;
  int         nbits;
  int         cs_low;
  int         sck_high;
  int         cs_high;

  initial begin
    prev_cs  = 1'b1;
    prev_sck = 1'b0;
    in_xfer  = 0;
    got_tx   = 8'h00;
    nbits    = 0;
    cs_low   = 0;
    sck_high = 0;
    cs_high  = 0;
  end

  always @(negedge clk) begin
    logic [15:0] e;
    if (rst) begin
      in_xfer  = 0;
      prev_cs  = 1'b1;
      prev_sck = 1'b0;
      cs_high  = 0;
    end else begin
      if (prev_cs && !cs) begin
        if (b2b_mode) check("cs_gap_cycles", cs_high, 1);
        in_xfer  = 1;
        got_tx   = 8'h00;
        nbits    = 0;
        cs_low   = 0;
        sck_high = 0;
      end
      if (!cs) cs_low++;
      if (cs) cs_high++; else cs_high = 0;
      if (in_xfer && sck) sck_high++;
      if (in_xfer && sck && !prev_sck) begin
        got_tx = {got_tx[6:0], mosi};
        nbits++;
      end
      if (in_xfer && !prev_cs && cs) begin
        in_xfer = 0;
        cs_high = 1;
        if (exp_q.size() == 0) begin
          check("unexpected_transfer", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("mosi_word", got_tx, e[15:8]);
          check("sck_pulses", nbits, 8);
          check("cs_low_cycles", cs_low, 17 * D);
          check("sck_high_cycles", sck_high, 8 * D);
          check("received_data", received_data, e[7:0]);
        end
      end
      prev_cs  = cs;
      prev_sck = sck;
    end
  end

  // Called at a falling clk edge; returns at the falling edge where busy is low.
  task automatic do_xfer(input logic [7:0] d, input logic [7:0] er, input bit mid, input logic [7:0] hold);
    int  cnt;
    bit  done;
    data      = d;
    load_data = 1'b1;
    exp_q.push_back({d, er});
    #1;
    check("busy_comb", busy, 1);
    cnt = 1;
    @(posedge clk);
    #1;
    load_data = 1'b0;
    data      = ~d;
    done      = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (mid && i == 10) begin
        data      = 8'hFF;
        load_data = 1'b1;
      end
      if (mid && i == 11) load_data = 1'b0;
      if (mid && i == 20) check("rd_held_mid", received_data, hold);
      if (busy) cnt++;
      else done = 1;
    end
    if (!done) check("busy_timeout", 0, 1);
    check("busy_cycles", cnt, 17 * D + 1);
    check("cs_idle_after", cs, 1);
  endtask

  logic [7:0] words [8];

  initial begin
    int rises;
    logic ps;
    words = '{8'hC3, 8'h01, 8'h80, 8'hFF, 8'h00, 8'h55, 8'hAA, 8'h7E};
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    data      = 8'h00;
    load_data = 1'b0;
    loop_en   = 1'b0;
    b2b_mode  = 0;

    #3;
    check("rst_cs", cs, 1);
    check("rst_sck", sck, 0);
    check("rst_mosi", mosi, 0);
    check("rst_busy", busy, 0);
    check("rst_rd", received_data, 8'h00);
    @(posedge clk); #2; rst = 1'b0;

    // Abort mid-transfer after the 4th SCK rise.
    loop_en = 1'b1;
    @(negedge clk);
    data = 8'h5A; load_data = 1'b1;
    @(posedge clk); #1; load_data = 1'b0;
    rises = 0;
    ps    = 1'b0;
    for (int i = 0; i < 100 && rises < 4; i++) begin
      @(negedge clk);
      if (sck && !ps) rises++;
      ps = sck;
    end
    check("abort_rises", rises, 4);
    #1 rst = 1'b1;
    #1;
    check("abort_cs", cs, 1);
    check("abort_sck", sck, 0);
    check("abort_mosi", mosi, 0);
    check("abort_busy", busy, 0);
    check("abort_rd", received_data, 8'h00);
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);

    // 0xA5 with miso tied low.
    loop_en = 1'b0;
    do_xfer(8'hA5, 8'h00, 0, 8'h00);

    // Loopback 0x3C.
    loop_en = 1'b1;
    do_xfer(8'h3C, 8'h3C, 0, 8'h00);

    // Hold check, then 0x81 with an ignored 0xFF request mid-transfer.
    loop_en = 1'b0;
    repeat (10) @(negedge clk);
    check("rd_held_idle", received_data, 8'h3C);
    do_xfer(8'h81, 8'h00, 1, 8'h3C);

    // Back-to-back registered requester, loopback.
    loop_en = 1'b1;
    repeat (3) @(negedge clk);
    for (int w = 0; w < 8; w++) begin
      do_xfer(words[w], words[w], 0, 8'h00);
      b2b_mode = 1;
    end
    b2b_mode = 0;

    repeat (20) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
